mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port 512x32 synchronous RAM between two requesters.
  - Port 0: CPU memory path (fetch/load/store).
  - Port 1: loader/DMA path (program load, I/O buffers).
- Per request, drives the RAM's read/write strobes, address and write data, then captures read data after the RAM's one-cycle registered read.
- Returns the result with a one-cycle ack pulse.
- Round-robin arbitration; write protection of the low program region against port 1.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 32, data width.
- PROT_LIMIT, 64, port-1 writes to addr < PROT_LIMIT are rejected; 0 disables protection.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request level.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 completion pulse.
- p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack is high.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1.
- p1_err  out  1  high with p1_ack when a protected write was rejected.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data (drives BusMuxOut).
- ram_rdata  in  DATA_W  RAM registered read data (MDataIn).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0: acks, err, ram strobes, ram_addr, ram_wdata, rdata registers.
  - Reset mid-access: strobes drop immediately; no write lands after reset asserts; the in-flight request gets no ack.
- FSM is IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - Eligible port = req high AND that port's ack low this cycle. The ack mask stops a port still holding req during its ack cycle from being re-granted.
  - One eligible port: grant it. Both eligible: grant the port != last_grant.
  - On grant: latch port id, we, addr, wdata; update last_grant; go to ACCESS.
  - Set ram_addr/ram_wdata. Set ram_read = !we or ram_write = we. For a protected port-1 write (p1, we=1, addr < PROT_LIMIT) set both strobes to 0.
- ACCESS (one cycle):
  - Strobes held high; the RAM acts at the end of this cycle.
  - Next state RESP; strobes cleared on the transition.
- RESP (one cycle):
  - ram_rdata is valid this cycle.
  - On the transition to IDLE, for the granted port:
    - rdata <= ram_rdata for reads; rdata keeps its previous value for writes.
    - ack <= 1 for one cycle.
    - p1_err <= rejected flag.
- Latency: req sampled in IDLE at cycle n gives ack high during cycle n+3. Best-case throughput is one access per 3 cycles. Back-to-back grants are allowed in the ack cycle for the other port.
- Handshake rules:
  - A requester holds req until ack and must drop req in the ack cycle.
  - addr/we/wdata need only be stable in the grant cycle.
  - req dropped before grant means the request is withdrawn, with no side effect.
  - req dropped after grant: the access completes and ack still pulses.
- Only one strobe is ever high; ram_read and ram_write are never high together.
- Port 0 is never write-protected.
- Address values beyond the RAM depth do not occur with ADDR_W = 9; the full 0..511 range passes through unchanged.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, ACCESS, RESP), port index constants (PORT_CPU = 0, PORT_DMA = 1), default ADDR_W/DATA_W.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from (eligible[1:0], last_grant), with a one-hot grant output.

Test Plan:
- Port 0 read: p0 reads addr 71 (contents 0x94) -> ram_read high in ACCESS only, p0_ack 3 cycles after req, p0_rdata = 0x00000094.
- Port 1 write then read: p1 writes 0xDEADBEEF to addr 200, then reads addr 200 -> ram_write pulses once, ack with p1_err = 0, read returns 0xDEADBEEF.
- Simultaneous requests: p0 and p1 both req out of reset, p0 reads 142, p1 reads 71 -> p0 granted first (rdata 0x34); p1 granted in p0's ack cycle (rdata 0x94); p0 not re-granted.
- Sustained contention: both hold req continuously for 6 accesses -> grants alternate 0,1,0,1,0,1; no port served twice in a row.
- Protection: p1 writes 0x0 to addr 10 -> ram_write never asserted, p1_ack with p1_err = 1, mem[10] unchanged on readback. p0 write to addr 10 succeeds.
- Reset during ACCESS of a p0 write to addr 300: ram_write drops immediately, no ack, busy = 0, FSM in IDLE. Next request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int PORT_CPU   = 0;
  localparam int PORT_DMA   = 1;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] elig_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = elig_i;
    if (&elig_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU path (port 0) and the
// loader/DMA path (port 1), with write protection of the low region against port 1.
//
//   state  | meaning
//   IDLE   | pick an eligible port, launch its strobe toward the RAM
//   ACCESS | strobe held; RAM reads/writes at the end of this cycle
//   RESP   | RAM read data valid; capture it and pulse the ack
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PROT_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  // One extra bit so a limit equal to the RAM depth still compares correctly.
  localparam logic [ADDR_W:0] PROT_LIM = PROT_LIMIT[ADDR_W:0];

  state_e            state_q;
  logic              last_q;
  logic              port_q;
  logic              we_q;
  logic              rej_q;
  logic              ram_read_q;
  logic              ram_write_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              p0_ack_q;
  logic              p1_ack_q;
  logic              p1_err_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic              sel_dma;
  logic              sel_we;
  logic              sel_rej;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port in its ack cycle may still hold req; masking it prevents a re-grant.
  assign elig = {p1_req & ~p1_ack_q, p0_req & ~p0_ack_q};

  rr_arbiter2 u_rr (
    .elig_i       (elig),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  assign sel_dma   = gnt[PORT_DMA];
  assign sel_we    = sel_dma ? p1_we    : p0_we;
  assign sel_addr  = sel_dma ? p1_addr  : p0_addr;
  assign sel_wdata = sel_dma ? p1_wdata : p0_wdata;
  assign sel_rej   = sel_dma & sel_we & ({1'b0, sel_addr} < PROT_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      rej_q       <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt[PORT_CPU] || gnt[PORT_DMA]) begin
            port_q      <= sel_dma;
            we_q        <= sel_we;
            rej_q       <= sel_rej;
            last_q      <= sel_dma;
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
            ram_read_q  <= ~sel_we;
            ram_write_q <= sel_we & ~sel_rej;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          if (port_q) begin
            p1_ack_q <= 1'b1;
            p1_err_q <= rej_q;
            if (!we_q) p1_rdata_q <= ram_rdata;
          end else begin
            p0_ack_q <= 1'b1;
            if (!we_q) p0_rdata_q <= ram_rdata;
          end
        end
        default: begin
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_ack    = p1_ack_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_err    = p1_err_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
